// File: rtl/ex_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : ex_result_buffer
// Purpose  : Execute-stage result collector. Selects the execute result
//            (ALU, shifter, immediate, set-less-than), tags it with its
//            destination register and write enable, and holds it in a
//            2-entry in-order skid buffer toward memory/writeback.
// Ports    : clk, rst (sync, active-high), flush
//            in_valid / in_ready, res_sel, alu_out, shift_out, imm_in,
//            rd_in, we_in                      -- execute side
//            out_valid / out_ready, out_data, out_rd, out_we,
//            out_zero, out_neg                 -- writeback side
// Config   : RESULT_FLAGS_EN -- when defined, zero/negative flags are
//            computed at push time and stored per entry; otherwise the
//            flag outputs are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module ex_result_buffer #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        res_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] shift_out,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [REG_W-1:0]  rd_in,
    input  logic              we_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_we,
    output logic              out_zero,
    output logic              out_neg
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Slot 0 is always the head; slot 1 only holds the second entry in TWO.
    logic [DATA_W-1:0] r_data0, r_data1;
    logic [REG_W-1:0]  r_rd0,   r_rd1;
    logic              r_we0,   r_we1;

    logic [DATA_W-1:0] w_result;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_push;
    logic              w_pop;
    logic              w_ld0_new;
    logic              w_ld0_from1;
    logic              w_ld1_new;

    always_comb begin
        w_result = alu_out;
        case (res_sel)
            2'b00:   w_result = alu_out;
            2'b01:   w_result = shift_out;
            2'b10:   w_result = imm_in;
            default: w_result = {{(DATA_W-1){1'b0}}, alu_out[DATA_W-1]};
        endcase
    end

    // Ready depends only on registered state, so out_ready never reaches
    // back into the execute datapath combinationally.
    assign w_in_ready  = (r_state != S_TWO);
    assign w_out_valid = (r_state != S_EMPTY);
    assign w_push      = in_valid  && w_in_ready;
    assign w_pop       = w_out_valid && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_ld0_new   = 1'b0;
        w_ld0_from1 = 1'b0;
        w_ld1_new   = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_push) begin
                    w_state_nxt = S_ONE;
                    w_ld0_new   = 1'b1;
                end
            end
            S_ONE: begin
                if (w_push && w_pop) begin
                    w_ld0_new = 1'b1;
                end else if (w_push) begin
                    w_state_nxt = S_TWO;
                    w_ld1_new   = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_TWO: begin
                if (w_pop) begin
                    w_state_nxt = S_ONE;
                    w_ld0_from1 = 1'b1;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
        // Flush discards both the held entries and this cycle's traffic.
        if (flush) begin
            w_state_nxt = S_EMPTY;
            w_ld0_new   = 1'b0;
            w_ld0_from1 = 1'b0;
            w_ld1_new   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data0 <= '0;
            r_rd0   <= '0;
            r_we0   <= 1'b0;
            r_data1 <= '0;
            r_rd1   <= '0;
            r_we1   <= 1'b0;
        end else begin
            if (w_ld0_new) begin
                r_data0 <= w_result;
                r_rd0   <= rd_in;
                r_we0   <= we_in;
            end else if (w_ld0_from1) begin
                r_data0 <= r_data1;
                r_rd0   <= r_rd1;
                r_we0   <= r_we1;
            end
            if (w_ld1_new) begin
                r_data1 <= w_result;
                r_rd1   <= rd_in;
                r_we1   <= we_in;
            end
        end
    end

`ifdef RESULT_FLAGS_EN
    logic r_zero0, r_zero1;
    logic r_neg0,  r_neg1;
    logic w_zero;
    logic w_neg;

    assign w_zero = (w_result == '0);
    assign w_neg  = w_result[DATA_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero0 <= 1'b0;
            r_neg0  <= 1'b0;
            r_zero1 <= 1'b0;
            r_neg1  <= 1'b0;
        end else begin
            if (w_ld0_new) begin
                r_zero0 <= w_zero;
                r_neg0  <= w_neg;
            end else if (w_ld0_from1) begin
                r_zero0 <= r_zero1;
                r_neg0  <= r_neg1;
            end
            if (w_ld1_new) begin
                r_zero1 <= w_zero;
                r_neg1  <= w_neg;
            end
        end
    end

    assign out_zero = r_zero0;
    assign out_neg  = r_neg0;
`else
    assign out_zero = 1'b0;
    assign out_neg  = 1'b0;
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_data0;
    assign out_rd    = r_rd0;
    assign out_we    = r_we0;

endmodule
`default_nettype wire

// File: tb/tb_ex_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_result_buffer
// Purpose  : Self-checking bench for ex_result_buffer: a table of directed
//            cycles covering reset, result select, back-pressure, push/pop
//            in ONE, flush and flags, then randomized traffic compared with
//            a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_result_buffer;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
`ifdef RESULT_FLAGS_EN
    localparam bit c_FLAGS = 1'b1;
`else
    localparam bit c_FLAGS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, in_ready;
    logic [1:0]        res_sel;
    logic [DATA_W-1:0] alu_out, shift_out, imm_in;
    logic [REG_W-1:0]  rd_in;
    logic              we_in;
    logic              out_valid, out_ready;
    logic [DATA_W-1:0] out_data;
    logic [REG_W-1:0]  out_rd;
    logic              out_we, out_zero, out_neg;

    int checks = 0;
    int errors = 0;

    ex_result_buffer #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .res_sel(res_sel),
        .alu_out(alu_out), .shift_out(shift_out), .imm_in(imm_in),
        .rd_in(rd_in), .we_in(we_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_we(out_we), .out_zero(out_zero), .out_neg(out_neg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, flush, iv;
        logic [1:0]  sel;
        logic [31:0] alu, sh, imm;
        logic [4:0]  rd;
        logic        we, ordy;
        logic        e_valid, e_ready, chk_d;
        logic [31:0] e_data;
        logic [4:0]  e_rd;
        logic        e_we, e_zero, e_neg;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } ent_t;

    vec_t vecs[20];
    ent_t mq[$];

    function automatic vec_t mk(
        input logic r, input logic f, input logic iv, input logic [1:0] sel,
        input logic [31:0] alu, input logic [31:0] sh, input logic [31:0] imm,
        input logic [4:0] rd, input logic we, input logic ordy,
        input logic ev, input logic er, input logic cd, input logic [31:0] ed,
        input logic [4:0] erd, input logic ewe, input logic ez, input logic en);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.sel = sel;
        v.alu = alu; v.sh = sh; v.imm = imm; v.rd = rd; v.we = we; v.ordy = ordy;
        v.e_valid = ev; v.e_ready = er; v.chk_d = cd; v.e_data = ed;
        v.e_rd = erd; v.e_we = ewe; v.e_zero = ez; v.e_neg = en;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_sel(input logic [1:0] sel, input logic [31:0] alu,
                                            input logic [31:0] sh, input logic [31:0] imm);
        case (sel)
            2'd0:    return alu;
            2'd1:    return sh;
            2'd2:    return imm;
            default: return (alu >> 31);   // signed "less than" bit of the compare
        endcase
    endfunction

    task automatic drive(input vec_t v);
        rst = v.rst; flush = v.flush; in_valid = v.iv; res_sel = v.sel;
        alu_out = v.alu; shift_out = v.sh; imm_in = v.imm;
        rd_in = v.rd; we_in = v.we; out_ready = v.ordy;
    endtask

    initial begin
        vec_t v;
        ent_t e;
        logic [31:0] d;
        bit push, pop;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; res_sel = 2'd0;
        alu_out = '0; shift_out = '0; imm_in = '0; rd_in = '0; we_in = 1'b0;
        out_ready = 1'b0;

        //            rst f iv sel  alu           shift         imm    rd we ordy  ev er cd data          erd we z n
        vecs[0]  = mk(1, 0, 0, 2'd0, 32'h0,        32'h0,        32'h0,  0, 0, 0,   0, 1, 1, 32'h0,        0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 2'd0, 32'h0,        32'h0,        32'h0,  0, 0, 0,   0, 1, 1, 32'h0,        0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h0,  0, 0, 0,   0, 1, 1, 32'h0,        0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 1, 2'd1, 32'h0,        32'hF0000000, 32'h0,  3, 1, 1,   1, 1, 1, 32'hF0000000, 3, 1, 0, 1);
        vecs[4]  = mk(0, 0, 1, 2'd3, 32'h80000000, 32'h0,        32'h0,  4, 1, 1,   1, 1, 1, 32'h1,        4, 1, 0, 0);
        vecs[5]  = mk(0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h0,  0, 0, 1,   0, 1, 0, 32'h0,        0, 0, 0, 0);
        vecs[6]  = mk(0, 0, 1, 2'd0, 32'hA,        32'h0,        32'h0,  1, 1, 0,   1, 1, 1, 32'hA,        1, 1, 0, 0);
        vecs[7]  = mk(0, 0, 1, 2'd2, 32'h0,        32'h0,        32'hB,  2, 1, 0,   1, 0, 1, 32'hA,        1, 1, 0, 0);
        vecs[8]  = mk(0, 0, 1, 2'd1, 32'h0,        32'hC,        32'h0,  5, 1, 0,   1, 0, 1, 32'hA,        1, 1, 0, 0);
        vecs[9]  = mk(0, 0, 1, 2'd1, 32'h0,        32'hC,        32'h0,  5, 1, 1,   1, 1, 1, 32'hB,        2, 1, 0, 0);
        vecs[10] = mk(0, 0, 1, 2'd1, 32'h0,        32'hC,        32'h0,  5, 1, 0,   1, 0, 1, 32'hB,        2, 1, 0, 0);
        vecs[11] = mk(0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h0,  0, 0, 1,   1, 1, 1, 32'hC,        5, 1, 0, 0);
        vecs[12] = mk(0, 0, 1, 2'd0, 32'hD,        32'h0,        32'h0,  6, 0, 1,   1, 1, 1, 32'hD,        6, 0, 0, 0);
        vecs[13] = mk(0, 0, 1, 2'd0, 32'hE,        32'h0,        32'h0,  7, 1, 0,   1, 0, 1, 32'hD,        6, 0, 0, 0);
        vecs[14] = mk(0, 1, 1, 2'd0, 32'hF,        32'h0,        32'h0,  8, 1, 1,   0, 1, 0, 32'h0,        0, 0, 0, 0);
        vecs[15] = mk(0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h0,  0, 0, 0,   0, 1, 0, 32'h0,        0, 0, 0, 0);
        vecs[16] = mk(0, 0, 1, 2'd0, 32'h0,        32'h0,        32'h0,  9, 0, 0,   1, 1, 1, 32'h0,        9, 0, 1, 0);
        vecs[17] = mk(0, 0, 1, 2'd2, 32'h0,        32'h0,        32'h55, 10, 1, 0,  1, 0, 1, 32'h0,        9, 0, 1, 0);
        vecs[18] = mk(1, 0, 1, 2'd0, 32'h77,       32'h0,        32'h0,  11, 1, 1,  0, 1, 1, 32'h0,        0, 0, 0, 0);
        vecs[19] = mk(0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h0,  0, 0, 0,   0, 1, 1, 32'h0,        0, 0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_valid});
            chk($sformatf("vec%0d in_ready", i),  {31'b0, in_ready},  {31'b0, vecs[i].e_ready});
            if (vecs[i].chk_d) begin
                chk($sformatf("vec%0d out_data", i), out_data, vecs[i].e_data);
                chk($sformatf("vec%0d out_rd", i),   {27'b0, out_rd}, {27'b0, vecs[i].e_rd});
                chk($sformatf("vec%0d out_we", i),   {31'b0, out_we}, {31'b0, vecs[i].e_we});
                chk($sformatf("vec%0d out_zero", i), {31'b0, out_zero}, {31'b0, vecs[i].e_zero & c_FLAGS});
                chk($sformatf("vec%0d out_neg", i),  {31'b0, out_neg},  {31'b0, vecs[i].e_neg & c_FLAGS});
            end
        end

        // Randomized traffic against an occupancy-queue reference model.
        mq.delete();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            v.rst   = ($urandom_range(0, 199) == 0);
            v.flush = ($urandom_range(0, 31) == 0);
            v.iv    = ($urandom_range(0, 3) != 0);
            v.sel   = 2'($urandom_range(0, 3));
            v.alu   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            v.sh    = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            v.imm   = $urandom;
            v.rd    = 5'($urandom);
            v.we    = 1'($urandom);
            v.ordy  = ($urandom_range(0, 2) != 0);
            drive(v);

            push = v.iv && (mq.size() < 2);
            pop  = v.ordy && (mq.size() > 0);
            if (v.rst || v.flush) begin
                mq.delete();
            end else begin
                if (pop) void'(mq.pop_front());
                if (push) begin
                    e.data = ref_sel(v.sel, v.alu, v.sh, v.imm);
                    e.rd   = v.rd;
                    e.we   = v.we;
                    mq.push_back(e);
                end
            end

            @(posedge clk);
            #1;
            chk("rnd out_valid", {31'b0, out_valid}, (mq.size() > 0) ? 32'd1 : 32'd0);
            chk("rnd in_ready",  {31'b0, in_ready},  (mq.size() < 2) ? 32'd1 : 32'd0);
            if (v.rst) begin
                chk("rnd rst out_data", out_data, 32'h0);
                chk("rnd rst out_rd",   {27'b0, out_rd}, 32'h0);
            end
            if (mq.size() > 0) begin
                d = mq[0].data;
                chk("rnd out_data", out_data, d);
                chk("rnd out_rd",   {27'b0, out_rd}, {27'b0, mq[0].rd});
                chk("rnd out_we",   {31'b0, out_we}, {31'b0, mq[0].we});
                chk("rnd out_zero", {31'b0, out_zero}, {31'b0, (d == 32'h0) & c_FLAGS});
                chk("rnd out_neg",  {31'b0, out_neg},  {31'b0, d[31] & c_FLAGS});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
